// File: rtl/rr_arbiter_16_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter.
package rr_arbiter_16_pkg;

    localparam int N_REQ        = 16;
    localparam int IDX_W        = 4;
    localparam int MAX_HOLD_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_16_grant_decoder.sv
// Gated 4-to-16 decoder: turns the next owner index into the one-hot
// resource select, forced to all zero when no grant is being issued.
module rr_arbiter_16_grant_decoder
    import rr_arbiter_16_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    // One bit set at the index position, only when enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with registered index/one-hot grant.
// The owner keeps the grant while its request stays high; a rotating
// priority pointer (one past the last winner) provides fairness.
// Optional macro GRANT_TIMEOUT_EN adds a hold counter that forces a release
// after MAX_HOLD consecutive grant cycles and pulses timeout for one cycle.
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             timeout
);

    // Reject hold limits the counter cannot represent.
    if (MAX_HOLD < 2 || MAX_HOLD > 65535 || (64'd1 << CNT_W) < 64'(MAX_HOLD)) begin : g_bad_params
        $error("rr_arbiter_16: illegal MAX_HOLD/CNT_W combination");
    end

    state_t           state;
    state_t           nxt_state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             nxt_valid;
    logic [IDX_W-1:0] nxt_idx;
    logic [N_REQ-1:0] nxt_onehot;

`ifdef GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_timeout;
`endif

    // Round-robin search: first requester at or after ptr, wrapping mod 16.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state decision: new grant from IDLE, hold or release from BUSY.
    always_comb begin
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_valid = grant_valid;
        nxt_idx   = grant_idx;
`ifdef GRANT_TIMEOUT_EN
        nxt_cnt     = hold_cnt;
        nxt_timeout = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en && found) begin
                    nxt_state = BUSY;
                    nxt_valid = 1'b1;
                    nxt_idx   = win;
                    // The winner drops to lowest priority for the next search.
                    nxt_ptr   = win + IDX_W'(1);
`ifdef GRANT_TIMEOUT_EN
                    nxt_cnt   = '0;
`endif
                end else begin
                    nxt_valid = 1'b0;
                    nxt_idx   = '0;
                end
            end
            BUSY: begin
                if (req[grant_idx]) begin
`ifdef GRANT_TIMEOUT_EN
                    if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        nxt_state   = IDLE;
                        nxt_valid   = 1'b0;
                        nxt_idx     = '0;
                        nxt_cnt     = '0;
                        nxt_timeout = 1'b1;
                    end else begin
                        nxt_cnt = hold_cnt + CNT_W'(1);
                    end
`endif
                end else begin
                    nxt_state = IDLE;
                    nxt_valid = 1'b0;
                    nxt_idx   = '0;
`ifdef GRANT_TIMEOUT_EN
                    nxt_cnt   = '0;
`endif
                end
            end
        endcase
    end

    rr_arbiter_16_grant_decoder u_grant_decoder (
        .idx    (nxt_idx),
        .en     (nxt_valid),
        .onehot (nxt_onehot)
    );

    // State, pointer and all grant outputs registered; async reset clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt     <= '0;
            timeout      <= 1'b0;
`endif
        end else begin
            state        <= nxt_state;
            ptr          <= nxt_ptr;
            grant_valid  <= nxt_valid;
            grant_idx    <= nxt_idx;
            grant_onehot <= nxt_onehot;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt     <= nxt_cnt;
            timeout      <= nxt_timeout;
`endif
        end
    end

`ifndef GRANT_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16 (MAX_HOLD=4); covers both builds of
// GRANT_TIMEOUT_EN.
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] req = 16'h0000;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        en;
        logic [15:0] req;
        logic        ev;
        logic [3:0]  ei;
        string       name;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_16 #(.MAX_HOLD(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Invariant: one-hot always matches the index when valid, zero otherwise.
    always @(negedge clk) begin
        n_cmp++;
        if (grant_onehot !== (grant_valid ? (16'd1 << grant_idx) : 16'd0)) begin
            n_bad++;
            $display("FAIL onehot_invariant: got onehot=%h (valid=%0b idx=%0d)",
                     grant_onehot, grant_valid, grant_idx);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic v, input logic [3:0] i, input logic t);
        logic [15:0] oh;
        oh = v ? (16'd1 << i) : 16'd0;
        n_cmp++;
        if (grant_valid !== v || grant_idx !== i || grant_onehot !== oh || timeout !== t) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b idx=%0d onehot=%h timeout=%0b, want valid=%0b idx=%0d onehot=%h timeout=%0b",
                     nm, grant_valid, grant_idx, grant_onehot, timeout, v, i, oh, t);
        end
    endtask

    task automatic add(input logic e, input logic [15:0] r, input logic v, input logic [3:0] i,
                       input string nm);
        vec_t x;
        x.en   = e;
        x.req  = r;
        x.ev   = v;
        x.ei   = i;
        x.name = nm;
        vecs.push_back(x);
    endtask

    initial begin
        // One record per cycle: inputs applied, outputs expected after the edge.
        add(1, 16'h0010, 1, 4,  "single_req_grant4");
        add(1, 16'h0010, 1, 4,  "single_req_hold4");
        add(1, 16'h0000, 0, 0,  "single_req_release");
        add(1, 16'h0000, 0, 0,  "no_req_no_grant");
        add(1, 16'h2000, 1, 13, "grant13");
        add(1, 16'h0000, 0, 0,  "release13");
        add(1, 16'h0009, 1, 0,  "wrap_grant0");
        add(1, 16'h0008, 0, 0,  "release0");
        add(1, 16'h0008, 1, 3,  "skip_grant3");
        add(1, 16'h0000, 0, 0,  "release3");
        add(1, 16'h0004, 1, 2,  "ptr4_wraps_to2");
        add(0, 16'h0004, 1, 2,  "en_low_holds2");
        add(0, 16'h0104, 1, 2,  "others_ignored");
        add(0, 16'h0100, 0, 0,  "release2_en_low");
        add(0, 16'h0100, 0, 0,  "en_low_blocks8_a");
        add(0, 16'h0100, 0, 0,  "en_low_blocks8_b");
        add(1, 16'h0100, 1, 8,  "en_high_grant8");
        add(1, 16'h0000, 0, 0,  "release8");
        add(1, 16'h0020, 1, 5,  "drop_grant5");
        add(1, 16'h0000, 0, 0,  "drop_release5");
        add(1, 16'h0000, 0, 0,  "drop_idle");

        // Reset asserted between edges; outputs must be zero at once and stay zero.
        #2 rst = 1'b1;
        #1 check("reset_async", 0, 0, 0);
        en  = 1'b1;
        req = 16'hFFFF;
        step;
        check("reset_hold_a", 0, 0, 0);
        step;
        check("reset_hold_b", 0, 0, 0);
        #3 rst = 1'b0;

        foreach (vecs[k]) begin
            en  = vecs[k].en;
            req = vecs[k].req;
            step;
            check(vecs[k].name, vecs[k].ev, vecs[k].ei, 1'b0);
        end

        // Async reset in the middle of a grant.
        en  = 1'b1;
        req = 16'h0080;
        step;
        check("pre_rst_grant7", 1, 7, 0);
        #3 rst = 1'b1;
        #1 check("async_rst_clears", 0, 0, 0);
        #1 rst = 1'b0;
        req = 16'hFFFF;

        // Rotation: everyone requesting, owner drops for one cycle after 3 grant cycles.
        for (int k = 0; k <= 16; k++) begin
            step;
            check($sformatf("rot%0d_grant", k), 1, 4'(k % 16), 0);
            step;
            check($sformatf("rot%0d_hold1", k), 1, 4'(k % 16), 0);
            step;
            check($sformatf("rot%0d_hold2", k), 1, 4'(k % 16), 0);
            req = 16'hFFFF & ~(16'd1 << (k % 16));
            step;
            check($sformatf("rot%0d_idle", k), 0, 0, 0);
            req = 16'hFFFF;
        end
        req = 16'h0000;
        step;
        check("rot_end_idle", 0, 0, 0);

        // Hold limit behaviour with two requesters held high.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        en  = 1'b1;
        req = 16'h0003;
`ifdef GRANT_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            step;
            check($sformatf("to_hold0_c%0d", c), 1, 0, 0);
        end
        step;
        check("to_pulse_idle", 0, 0, 1);
        step;
        check("to_regrant1", 1, 1, 0);
        req = 16'h0000;
        step;
        check("to_release1", 0, 0, 0);
`else
        for (int c = 0; c < 10; c++) begin
            step;
            check($sformatf("nohold_limit_c%0d", c), 1, 0, 0);
        end
        req = 16'h0000;
        step;
        check("nohold_release0", 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
